// File: rtl/pbpix_stream_arbiter.sv
// Burst-locked round-robin arbiter sharing one registered pbpix stream
// among N_REQ producers; one beat per cycle within a burst.
module pbpix_stream_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 16,
    parameter int BURST = 8,
    localparam int IDW  = $clog2(N_REQ)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [N_REQ-1:0]   req_rdy,
    output logic [N_REQ-1:0]   req_ack,
    input  logic [N_REQ-1:0]   req_zero,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic               gnt_rdy,
    input  logic               gnt_ack,
    output logic               gnt_zero,
    output logic [DW-1:0]      gnt_data,
    output logic [IDW-1:0]     gnt_id,
    output logic               busy
);

    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IDW-1:0]  r_rr_ptr;
    logic [IDW-1:0]  r_owner;
    logic [CW-1:0]   r_cnt;
    logic            r_gnt_rdy;
    logic            r_gnt_zero;
    logic [DW-1:0]   r_gnt_data;
    logic [IDW-1:0]  r_gnt_id;

    logic [IDW-1:0]  w_pick;
    logic [IDW:0]    w_idx;
    logic            w_any;
    logic            w_owner_rdy;
    logic            w_xfer;
    logic            w_last;
    logic            w_release;
    logic [IDW-1:0]  w_owner_inc;
    logic [DW-1:0]   w_sel_data;

    // Descending scan so the lowest cyclic offset from r_rr_ptr wins.
    always_comb begin
        w_pick = '0;
        w_idx  = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(N_REQ))
                w_idx = w_idx - (IDW+1)'(N_REQ);
            if (req_rdy[w_idx])
                w_pick = w_idx[IDW-1:0];
        end
    end

    assign w_any       = |req_rdy;
    assign w_owner_rdy = req_rdy[r_owner];
    assign w_xfer      = (r_state == S_GRANT) && w_owner_rdy
                         && (!r_gnt_rdy || gnt_ack);
    assign w_last      = (r_cnt == CW'(BURST - 1));
    assign w_release   = (r_state == S_GRANT)
                         && (!w_owner_rdy || (w_xfer && w_last));
    assign w_owner_inc = (r_owner == IDW'(N_REQ - 1)) ? '0
                                                       : r_owner + 1'b1;
    assign w_sel_data  = req_data[r_owner*DW +: DW];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_any)     w_state_nxt = S_GRANT;
            S_GRANT: if (w_release) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        req_ack = '0;
        if (w_xfer)
            req_ack[r_owner] = 1'b1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
        end else begin
            if (r_state == S_IDLE && w_any) begin
                r_owner <= w_pick;
                r_cnt   <= '0;
            end else if (w_xfer) begin
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            if (w_release)
                r_rr_ptr <= w_owner_inc;
        end
    end

    // Load wins over drain, so a concurrent load/drain keeps gnt_rdy high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_gnt_rdy  <= 1'b0;
            r_gnt_zero <= 1'b0;
            r_gnt_data <= '0;
            r_gnt_id   <= '0;
        end else if (w_xfer) begin
            r_gnt_rdy  <= 1'b1;
            r_gnt_zero <= req_zero[r_owner];
            r_gnt_data <= w_sel_data;
            r_gnt_id   <= r_owner;
        end else if (gnt_ack) begin
            r_gnt_rdy  <= 1'b0;
        end
    end

    assign gnt_rdy  = r_gnt_rdy;
    assign gnt_zero = r_gnt_zero;
    assign gnt_data = r_gnt_data;
    assign gnt_id   = r_gnt_id;
    assign busy     = (r_state == S_GRANT) || r_gnt_rdy;

endmodule
